// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: write port, two read ports and the soft-clear handshake.
// The master drives requests and addresses; the slave (the register file) returns data and status.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addrA;
  logic [ADDR_W-1:0] rd_addrB;
  logic [DATA_W-1:0] rd_dataA;
  logic [DATA_W-1:0] rd_dataB;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addrA, rd_addrB, clr_req,
    input  rd_dataA, rd_dataB, clr_busy, clr_done, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addrA, rd_addrB, clr_req,
    output rd_dataA, rd_dataB, clr_busy, clr_done, wr_drop
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports, one write port, r0 hardwired to zero,
// and a soft-clear sweep engine. Define REGFILE_BYPASS_EN to forward same-edge writes to reads.
module regfile_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 252
) (
  input  logic            elk,
  input  logic            nrst,
  regfile_param_if.slave  bus
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] SP_RST  = DATA_W'(SP_INIT);
  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LAST    = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              busy_nxt, done_nxt, drop_nxt;
  logic              busy_p1, done_p1, drop_p1;

  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rd_a_nxt, rd_b_nxt;
  logic [DATA_W-1:0] rd_a_p1, rd_b_p1;

  function automatic logic [DATA_W-1:0] reset_val(input logic [ADDR_W-1:0] i);
    return (i == SP_ADDR) ? SP_RST : '0;
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    drop_nxt  = 1'b0;
    w_en      = 1'b0;
    w_addr    = bus.wr_addr;
    w_data    = bus.wr_data;
    case (state)
      IDLE: begin
        // An external write on the triggering edge still lands; the sweep erases it later.
        w_en = bus.wr_en;
        if (bus.clr_req) begin
          state_nxt = SWEEP;
          idx_nxt   = {{(ADDR_W-1){1'b0}}, 1'b1};
          busy_nxt  = 1'b1;
        end
      end
      SWEEP: begin
        w_en     = 1'b1;
        w_addr   = idx;
        w_data   = reset_val(idx);
        drop_nxt = bus.wr_en;
        idx_nxt  = idx + ADDR_W'(1);
        busy_nxt = 1'b1;
        if (idx == LAST) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (w_addr == '0) w_en = 1'b0;
  end

  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      state   <= IDLE;
      idx     <= {{(ADDR_W-1){1'b0}}, 1'b1};
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
      drop_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      busy_p1 <= busy_nxt;
      done_p1 <= done_nxt;
      drop_p1 <= drop_nxt;
    end
  end

  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= reset_val(ADDR_W'(i));
    end else if (w_en) begin
      regs[w_addr] <= w_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_a_nxt = (w_en && (w_addr == bus.rd_addrA)) ? w_data : regs[bus.rd_addrA];
    rd_b_nxt = (w_en && (w_addr == bus.rd_addrB)) ? w_data : regs[bus.rd_addrB];
  end
`else
  always_comb begin
    rd_a_nxt = regs[bus.rd_addrA];
    rd_b_nxt = regs[bus.rd_addrB];
  end
`endif

  // Read stage: one-cycle registered output
  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      rd_a_p1 <= '0;
      rd_b_p1 <= '0;
    end else begin
      rd_a_p1 <= rd_a_nxt;
      rd_b_p1 <= rd_b_nxt;
    end
  end

  assign bus.rd_dataA = rd_a_p1;
  assign bus.rd_dataB = rd_b_p1;
  assign bus.clr_busy = busy_p1;
  assign bus.clr_done = done_p1;
  assign bus.wr_drop  = drop_p1;

endmodule
